pulse_analyzer: RTL and testbench

- Receive-side counterpart of the exponential signal generator: consumes one filter output stream and reduces each pulse to an event record (amplitude, peak time, width, pile-up flag).
- Sits after any filter_vN output in the filter top level.
- Presents events through a single-entry valid/ready output register.
- Keeps saturating counters of accepted and lost events.

---
 rtl/pulse_analyzer_pkg.sv | 23 ++
 rtl/pulse_analyzer_sat_counter.sv | 34 +++
 rtl/pulse_analyzer.sv | 199 +++++++++++++++++++
 tb/tb_pulse_analyzer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_analyzer_pkg.sv
// Shared types and sizes for the pulse analyzer.
//   SIZE_FILTER_DATA : default filtered-sample width
//   SIZE_EVENT_TIME  : default width of the peak_time and width fields
//   event_t          : event record layout at the default widths
//   pa_state_t       : analyzer FSM states
package pulse_analyzer_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_EVENT_TIME  = 16;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amplitude;
        logic [SIZE_EVENT_TIME-1:0]         peak_time;
        logic [SIZE_EVENT_TIME-1:0]         width;
        logic                               pileup;
    } event_t;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } pa_state_t;

endpackage

// File: rtl/pulse_analyzer_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   inc   : increment request for this cycle
//   count : current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_analyzer.sv
// Reduces each above-threshold pulse of a filtered sample stream to an event
// record (amplitude, peak time, width, pile-up) held in a single-entry
// valid/ready output register, with saturating accepted/lost event counters.
//   clk, reset           : system clock, synchronous active-high reset
//   enable               : analysis enable; dropping it mid-pulse aborts the pulse
//   input_data           : signed filtered sample, one per clock
//   threshold            : signed trigger level
//   event_valid/ready    : output record handshake
//   event_amplitude      : peak sample value
//   event_peak_time      : samples from threshold crossing to peak
//   event_width          : samples above threshold
//   event_pileup         : pile-up or timeout seen
//   event_count          : records loaded into the output register
//   lost_count           : records dropped because the output register was full
//
// state | meaning
// IDLE  | waiting for a rising threshold crossing (above && !prev_above)
// TRACK | inside a pulse, updating peak, width, valley and pile-up flag
module pulse_analyzer
    import pulse_analyzer_pkg::*;
#(
    parameter int DATA_W    = SIZE_FILTER_DATA,
    parameter int TIME_W    = SIZE_EVENT_TIME,
    parameter int HYST      = 8,
    parameter int MAX_WIDTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        input_data,
    input  logic [DATA_W-1:0]        threshold,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic signed [DATA_W-1:0] event_amplitude,
    output logic [TIME_W-1:0]        event_peak_time,
    output logic [TIME_W-1:0]        event_width,
    output logic                     event_pileup,
    output logic [31:0]              event_count,
    output logic [15:0]              lost_count
);

    localparam int AW = DATA_W + 1;
    localparam logic signed [AW-1:0] HYST_W = AW'(HYST);

    pa_state_t state_q, state_d;
    logic signed [DATA_W-1:0] x_q, x_d, amp_q, amp_d, vmin_q, vmin_d, ev_amp_q, ev_amp_d;
    logic [TIME_W-1:0] pk_q, pk_d, wid_q, wid_d, ev_pk_q, ev_pk_d, ev_wid_q, ev_wid_d;
    logic x_vld_q, x_vld_d, prev_above_q, prev_above_d;
    logic fell_q, fell_d, pu_q, pu_d, done_q, done_d;
    logic ev_valid_q, ev_valid_d, ev_pu_q, ev_pu_d;
    logic above, ev_load, ev_lost;
    logic signed [AW-1:0] x_w;

    assign above = x_q > $signed(threshold);
    assign x_w   = $signed({x_q[DATA_W-1], x_q});

    always_comb begin
        x_d          = input_data;
        x_vld_d      = 1'b1;
        // x is not a real sample until one has been captured after reset, so
        // prev_above holds its reset value of 1 until then.
        prev_above_d = x_vld_q ? above : prev_above_q;
        state_d      = state_q;
        amp_d        = amp_q;
        vmin_d       = vmin_q;
        pk_d         = pk_q;
        wid_d        = wid_q;
        fell_d       = fell_q;
        pu_d         = pu_q;
        done_d       = 1'b0;
        ev_valid_d   = ev_valid_q;
        ev_amp_d     = ev_amp_q;
        ev_pk_d      = ev_pk_q;
        ev_wid_d     = ev_wid_q;
        ev_pu_d      = ev_pu_q;
        ev_load      = 1'b0;
        ev_lost      = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && above && !prev_above_q) begin
                    state_d = TRACK;
                    amp_d   = x_q;
                    vmin_d  = x_q;
                    pk_d    = '0;
                    wid_d   = TIME_W'(1);
                    fell_d  = 1'b0;
                    pu_d    = 1'b0;
                end
            end
            TRACK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (!above) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (wid_q == TIME_W'(MAX_WIDTH)) begin
                    state_d = IDLE;
                    pu_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    wid_d = wid_q + 1'b1;
                    if (x_q > amp_q) begin
                        amp_d  = x_q;
                        pk_d   = wid_q;
                        vmin_d = x_q;
                        fell_d = 1'b0;
                    end else if (x_q < vmin_q) begin
                        vmin_d = x_q;
                    end
                    if (($signed({amp_d[DATA_W-1], amp_d}) - x_w) >= HYST_W) begin
                        fell_d = 1'b1;
                    end
                    if (fell_d && (x_w > ($signed({vmin_d[DATA_W-1], vmin_d}) + HYST_W))) begin
                        pu_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Hand-off runs one cycle after the pulse ends. The working registers
        // still hold the finished record then, even if a new pulse triggers
        // on the same edge.
        if (done_q) begin
            if (!ev_valid_q || event_ready) begin
                ev_valid_d = 1'b1;
                ev_amp_d   = amp_q;
                ev_pk_d    = pk_q;
                ev_wid_d   = wid_q;
                ev_pu_d    = pu_q;
                ev_load    = 1'b1;
            end else begin
                ev_lost = 1'b1;
            end
        end else if (ev_valid_q && event_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            x_vld_q      <= 1'b0;
            prev_above_q <= 1'b1;
            amp_q        <= '0;
            vmin_q       <= '0;
            pk_q         <= '0;
            wid_q        <= '0;
            fell_q       <= 1'b0;
            pu_q         <= 1'b0;
            done_q       <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_amp_q     <= '0;
            ev_pk_q      <= '0;
            ev_wid_q     <= '0;
            ev_pu_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            x_vld_q      <= x_vld_d;
            prev_above_q <= prev_above_d;
            amp_q        <= amp_d;
            vmin_q       <= vmin_d;
            pk_q         <= pk_d;
            wid_q        <= wid_d;
            fell_q       <= fell_d;
            pu_q         <= pu_d;
            done_q       <= done_d;
            ev_valid_q   <= ev_valid_d;
            ev_amp_q     <= ev_amp_d;
            ev_pk_q      <= ev_pk_d;
            ev_wid_q     <= ev_wid_d;
            ev_pu_q      <= ev_pu_d;
        end
    end

    sat_counter #(.WIDTH(32)) u_event_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev_load),
        .count (event_count)
    );

    sat_counter #(.WIDTH(16)) u_lost_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev_lost),
        .count (lost_count)
    );

    assign event_valid     = ev_valid_q;
    assign event_amplitude = ev_amp_q;
    assign event_peak_time = ev_pk_q;
    assign event_width     = ev_wid_q;
    assign event_pileup    = ev_pu_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Directed bench for pulse_analyzer with MAX_WIDTH reduced to 16.
module tb_pulse_analyzer;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [15:0]        input_data;
    logic [15:0]        threshold;
    logic               event_valid;
    logic               event_ready;
    logic signed [15:0] event_amplitude;
    logic [15:0]        event_peak_time;
    logic [15:0]        event_width;
    logic               event_pileup;
    logic [31:0]        event_count;
    logic [15:0]        lost_count;

    int n_checks = 0;
    int n_pass   = 0;
    int nvalid;
    logic [15:0] cap_amp, cap_pk, cap_wid;
    logic        cap_pu;
    int seq[$];

    pulse_analyzer #(
        .DATA_W    (16),
        .TIME_W    (16),
        .HYST      (8),
        .MAX_WIDTH (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .input_data      (input_data),
        .threshold       (threshold),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .event_amplitude (event_amplitude),
        .event_peak_time (event_peak_time),
        .event_width     (event_width),
        .event_pileup    (event_pileup),
        .event_count     (event_count),
        .lost_count      (lost_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present one sample, let it be captured, then sample outputs 1 ns later.
    task automatic step(input int v);
        input_data = 16'(v);
        @(posedge clk);
        #1;
        if (event_valid) begin
            nvalid++;
            cap_amp = event_amplitude;
            cap_pk  = event_peak_time;
            cap_wid = event_width;
            cap_pu  = event_pileup;
        end
    endtask

    task automatic feed_seq();
        foreach (seq[i]) step(seq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        event_ready = 1'b1;
        threshold   = 16'd100;
        input_data  = 16'd0;
        nvalid      = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(event_valid), 0);
        check("rst_amp", 32'(event_amplitude), 0);
        check("rst_pk", 32'(event_peak_time), 0);
        check("rst_wid", 32'(event_width), 0);
        check("rst_pu", 32'(event_pileup), 0);
        check("rst_evcnt", event_count, 0);
        check("rst_lost", 32'(lost_count), 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) step(0);

        // 1: single pulse, latency and one-cycle valid
        seq = '{0, 50, 120, 200, 300, 250, 150, 90};
        feed_seq();
        check("t1_valid_k", 32'(event_valid), 0);
        step(0);
        check("t1_valid_k1", 32'(event_valid), 0);
        step(0);
        check("t1_valid_k2", 32'(event_valid), 1);
        check("t1_amp", 32'(event_amplitude), 300);
        check("t1_pk", 32'(event_peak_time), 2);
        check("t1_wid", 32'(event_width), 5);
        check("t1_pu", 32'(event_pileup), 0);
        check("t1_evcnt", event_count, 1);
        step(0);
        check("t1_valid_drop", 32'(event_valid), 0);

        // 2: pile-up
        nvalid = 0;
        seq = '{0, 120, 300, 200, 150, 250, 90};
        feed_seq();
        repeat (4) step(0);
        check("t2_nvalid", 32'(nvalid), 1);
        check("t2_amp", 32'(cap_amp), 300);
        check("t2_pk", 32'(cap_pk), 1);
        check("t2_wid", 32'(cap_wid), 5);
        check("t2_pu", 32'(cap_pu), 1);
        check("t2_evcnt", event_count, 2);

        // 3: backpressure, second record dropped
        event_ready = 1'b0;
        seq = '{0, 50, 120, 200, 300, 250, 150, 90};
        feed_seq();
        repeat (3) step(0);
        check("t3_valid_held", 32'(event_valid), 1);
        seq = '{0, 130, 90};
        feed_seq();
        repeat (3) step(0);
        check("t3_valid_still", 32'(event_valid), 1);
        check("t3_amp", 32'(event_amplitude), 300);
        check("t3_pk", 32'(event_peak_time), 2);
        check("t3_wid", 32'(event_width), 5);
        check("t3_lost", 32'(lost_count), 1);
        check("t3_evcnt", event_count, 3);
        event_ready = 1'b1;
        step(0);
        event_ready = 1'b0;
        check("t3_valid_accepted", 32'(event_valid), 0);
        check("t3_evcnt_after", event_count, 3);
        event_ready = 1'b1;

        // 4: timeout at MAX_WIDTH=16, then re-arm
        nvalid = 0;
        step(0);
        repeat (40) step(500);
        check("t4_nvalid", 32'(nvalid), 1);
        check("t4_amp", 32'(cap_amp), 500);
        check("t4_pk", 32'(cap_pk), 0);
        check("t4_wid", 32'(cap_wid), 16);
        check("t4_pu", 32'(cap_pu), 1);
        nvalid = 0;
        seq = '{0, 0, 500, 0, 0, 0, 0};
        feed_seq();
        check("t4_rearm_nvalid", 32'(nvalid), 1);
        check("t4_rearm_wid", 32'(cap_wid), 1);
        check("t4_rearm_pu", 32'(cap_pu), 0);
        check("t4_evcnt", event_count, 5);

        // 5: reset mid-pulse
        seq = '{0, 50, 120, 200};
        feed_seq();
        reset = 1'b1;
        step(300);
        reset = 1'b0;
        check("t5_rst_valid", 32'(event_valid), 0);
        check("t5_rst_amp", 32'(event_amplitude), 0);
        check("t5_rst_wid", 32'(event_width), 0);
        check("t5_rst_evcnt", event_count, 0);
        nvalid = 0;
        seq = '{250, 150, 90, 0, 0, 0};
        feed_seq();
        check("t5_no_event", 32'(nvalid), 0);
        seq = '{0, 50, 120, 200, 300, 250, 150, 90, 0, 0, 0};
        feed_seq();
        check("t5_nvalid", 32'(nvalid), 1);
        check("t5_amp", 32'(cap_amp), 300);
        check("t5_evcnt", event_count, 1);

        // 6: enable drop mid-pulse, no retrigger while still above
        nvalid = 0;
        seq = '{0, 120, 200};
        feed_seq();
        enable = 1'b0;
        step(300);
        enable = 1'b1;
        seq = '{250, 150, 90, 0, 0, 0};
        feed_seq();
        check("t6_no_event", 32'(nvalid), 0);
        check("t6_evcnt_same", event_count, 1);
        check("t6_lost_same", 32'(lost_count), 0);
        seq = '{200, 0, 0, 0, 0};
        feed_seq();
        check("t6_nvalid", 32'(nvalid), 1);
        check("t6_amp", 32'(cap_amp), 200);
        check("t6_wid", 32'(cap_wid), 1);
        check("t6_pk", 32'(cap_pk), 0);
        check("t6_evcnt", event_count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
